// File: rtl/bcrypt_core_output_serializer.sv
// Core-side 1-bit result serializer: buffers 16x16-bit packets, shifts out header + 256 bits LSB-first.
// Optional ping-pong buffering enabled by defining BCRYPT_OUTPUT_DOUBLE_BUF_EN.
module bcrypt_core_output_serializer #(
    parameter int unsigned PKT_NUM_WORDS = 16
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [15:0] din,
    input  logic        wr_en,
    output logic        wr_ready,
    input  logic        rd_en,
    output logic        empty,
    output logic        dout,
    output logic        err_overflow
);

    localparam int unsigned WORD_W   = 16;
    localparam int unsigned WCNT_W   = $clog2(PKT_NUM_WORDS);
    localparam int unsigned WBIT_W   = $clog2(WORD_W);
    localparam int unsigned PKT_BITS = PKT_NUM_WORDS * WORD_W;
    localparam int unsigned BCNT_W   = $clog2(PKT_BITS);
    localparam int unsigned NUM_BUF  = 2;

    localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(PKT_NUM_WORDS - 1);
    localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(PKT_BITS - 1);

`ifdef BCRYPT_OUTPUT_DOUBLE_BUF_EN
    localparam logic PING_PONG = 1'b1;
`else
    // Single buffer: selectors never toggle, so the second buffer is never used.
    localparam logic PING_PONG = 1'b0;
`endif

    typedef enum logic [1:0] {
        BUF_FREE,
        BUF_FILLING,
        BUF_FULL,
        BUF_SENDING
    } buf_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_HEADER,
        TX_DATA
    } tx_state_t;

    tx_state_t          r_tx_state;
    tx_state_t          w_tx_state_nxt;
    buf_state_t         r_buf_state     [NUM_BUF];
    buf_state_t         w_buf_state_nxt [NUM_BUF];
    logic [WORD_W-1:0]  r_mem [NUM_BUF][PKT_NUM_WORDS];

    logic [WCNT_W-1:0]  r_wr_cnt;
    logic [BCNT_W-1:0]  r_bit_cnt;
    logic               r_wr_sel;
    logic               r_rd_sel;
    logic               r_tx_sel;
    logic               r_wr_ready;
    logic               r_empty;
    logic               r_dout;
    logic               r_err_overflow;

    logic               w_wr_fire;
    logic               w_commit;
    logic               w_rd_accept;
    logic               w_tx_last;
    logic               w_wr_sel_nxt;
    logic               w_rd_sel_nxt;
    logic               w_dout_nxt;
    logic               w_empty_nxt;
    logic               w_wr_ready_nxt;
    logic [BCNT_W-1:0]  w_rd_addr;
    logic               w_rd_bit;

    assign w_wr_fire   = wr_en & r_wr_ready;
    assign w_commit    = w_wr_fire & (r_wr_cnt == WORD_LAST);
    assign w_rd_accept = rd_en & ~r_empty & (r_tx_state == TX_IDLE);
    assign w_tx_last   = (r_tx_state == TX_DATA) && (r_bit_cnt == BIT_LAST);

    assign w_wr_sel_nxt = w_commit    ? (r_wr_sel ^ PING_PONG) : r_wr_sel;
    assign w_rd_sel_nxt = w_rd_accept ? (r_rd_sel ^ PING_PONG) : r_rd_sel;

    // Prefetch the bit that goes on the wire next cycle; upper bits pick the word.
    assign w_rd_addr = (r_tx_state == TX_DATA) ? (r_bit_cnt + BCNT_W'(1)) : '0;
    assign w_rd_bit  = r_mem[r_tx_sel][w_rd_addr[BCNT_W-1:WBIT_W]][w_rd_addr[WBIT_W-1:0]];

    // Transmitter state register
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_tx_state <= TX_IDLE;
        end else begin
            r_tx_state <= w_tx_state_nxt;
        end
    end

    // Transmitter next state and next serial bit
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_dout_nxt     = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (w_rd_accept) begin
                    w_tx_state_nxt = TX_HEADER;
                    w_dout_nxt     = 1'b1;
                end
            end
            TX_HEADER: begin
                w_tx_state_nxt = TX_DATA;
                w_dout_nxt     = w_rd_bit;
            end
            TX_DATA: begin
                if (w_tx_last) begin
                    w_tx_state_nxt = TX_IDLE;
                end else begin
                    w_dout_nxt = w_rd_bit;
                end
            end
            default: begin
                w_tx_state_nxt = TX_IDLE;
            end
        endcase
    end

    // Buffer lifecycle: FREE -> FILLING -> FULL -> SENDING -> FREE
    always_comb begin
        for (int b = 0; b < NUM_BUF; b++) begin
            w_buf_state_nxt[b] = r_buf_state[b];
        end
        if (w_wr_fire) begin
            w_buf_state_nxt[r_wr_sel] = w_commit ? BUF_FULL : BUF_FILLING;
        end
        if (w_rd_accept) begin
            w_buf_state_nxt[r_rd_sel] = BUF_SENDING;
        end
        if (w_tx_last) begin
            w_buf_state_nxt[r_tx_sel] = BUF_FREE;
        end
    end

    // Status flags are derived from the post-edge buffer states
    always_comb begin
        w_empty_nxt = 1'b1;
        for (int b = 0; b < NUM_BUF; b++) begin
            if (w_buf_state_nxt[b] == BUF_FULL) begin
                w_empty_nxt = 1'b0;
            end
        end
        w_wr_ready_nxt = (w_buf_state_nxt[w_wr_sel_nxt] == BUF_FREE) ||
                         (w_buf_state_nxt[w_wr_sel_nxt] == BUF_FILLING);
    end

    // Control and status registers
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            for (int b = 0; b < NUM_BUF; b++) begin
                r_buf_state[b] <= BUF_FREE;
            end
            r_wr_cnt       <= '0;
            r_bit_cnt      <= '0;
            r_wr_sel       <= 1'b0;
            r_rd_sel       <= 1'b0;
            r_tx_sel       <= 1'b0;
            r_wr_ready     <= 1'b1;
            r_empty        <= 1'b1;
            r_dout         <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            for (int b = 0; b < NUM_BUF; b++) begin
                r_buf_state[b] <= w_buf_state_nxt[b];
            end
            if (w_wr_fire) begin
                r_wr_cnt <= w_commit ? '0 : (r_wr_cnt + WCNT_W'(1));
            end
            if (r_tx_state == TX_HEADER) begin
                r_bit_cnt <= '0;
            end else if (r_tx_state == TX_DATA) begin
                r_bit_cnt <= r_bit_cnt + BCNT_W'(1);
            end
            if (w_rd_accept) begin
                r_tx_sel <= r_rd_sel;
            end
            r_wr_sel       <= w_wr_sel_nxt;
            r_rd_sel       <= w_rd_sel_nxt;
            r_wr_ready     <= w_wr_ready_nxt;
            r_empty        <= w_empty_nxt;
            r_dout         <= w_dout_nxt;
            r_err_overflow <= r_err_overflow | (wr_en & ~r_wr_ready);
        end
    end

    // Packet storage (distributed RAM, no reset)
    always_ff @(posedge CLK) begin
        if (w_wr_fire) begin
            r_mem[r_wr_sel][r_wr_cnt] <= din;
        end
    end

    assign wr_ready     = r_wr_ready;
    assign empty        = r_empty;
    assign dout         = r_dout;
    assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_bcrypt_core_output_serializer.sv
// Scoreboard bench for bcrypt_core_output_serializer; stimulus queues expected packets, a monitor deserializes dout.
module tb_bcrypt_core_output_serializer;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [15:0] din = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_ready;
    logic        empty;
    logic        dout;
    logic        err_overflow;

    bcrypt_core_output_serializer #(.PKT_NUM_WORDS(16)) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .din          (din),
        .wr_en        (wr_en),
        .wr_ready     (wr_ready),
        .rd_en        (rd_en),
        .empty        (empty),
        .dout         (dout),
        .err_overflow (err_overflow)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [255:0] data;
        int           hdr_cyc;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           mon_st = 0;
    int           mon_k = 0;
    logic [255:0] mon_cap = '0;
    exp_t         mon_cur;
    bit           mon_abort = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 256'(act), 256'(exp));
    endtask

    // Monitor: header detection, 256-bit capture, trailing-zero check
    always @(negedge CLK) begin
        if (mon_abort) begin
            mon_st = 0;
            mon_k  = 0;
        end else begin
            case (mon_st)
                0: begin
                    if (dout === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            chk1("spurious_header", dout, 1'b0);
                        end else begin
                            mon_cur = exp_q.pop_front();
                            chk("header_cycle", 256'(cyc), 256'(mon_cur.hdr_cyc));
                            mon_k  = 0;
                            mon_st = 1;
                        end
                    end
                end
                1: begin
                    mon_cap[mon_k] = dout;
                    mon_k++;
                    if (mon_k == 256) begin
                        for (int w = 0; w < 16; w++) begin
                            chk($sformatf("pkt_word%0d", w), 256'(mon_cap[16*w +: 16]),
                                256'(mon_cur.data[16*w +: 16]));
                        end
                        mon_st = 2;
                    end
                end
                default: begin
                    chk1("tail_zero", dout, 1'b0);
                    mon_st = 0;
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_words(input logic [255:0] p, input logic exp_empty_pre);
        for (int i = 0; i < 16; i++) begin
            din   = p[16*i +: 16];
            wr_en = 1'b1;
            if (i == 15) chk1("empty_pre_commit", empty, exp_empty_pre);
            tick();
        end
    endtask

    task automatic write_pkt(input logic [255:0] p, input logic exp_empty_pre);
        write_words(p, exp_empty_pre);
        wr_en = 1'b0;
        din   = '0;
    endtask

    task automatic rd_pulse(input logic [255:0] p, input bit accept, output int n);
        n     = cyc + 1;
        rd_en = 1'b1;
        if (accept) exp_q.push_back('{data: p, hdr_cyc: n});
        tick();
        rd_en = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || mon_st != 0) && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        chk(name, 256'(exp_q.size() + mon_st), 256'(0));
    endtask

    task automatic quiet(input string name, input int ncyc);
        logic ok = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge CLK);
            if (dout !== 1'b0) ok = 1'b0;
        end
        chk1(name, ok, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [255:0] p0, p1, p2, pc, pd, pe;
    int           n;

    initial begin
        for (int i = 0; i < 16; i++) begin
            p0[16*i +: 16] = 16'(i);
            p1[16*i +: 16] = 16'(16'h3C5A ^ (i * 16'h1111));
            p2[16*i +: 16] = 16'(16'hF00D + i * 16'h0123);
            pc[16*i +: 16] = 16'(16'h8421 ^ (i * 16'h0707));
            pd[16*i +: 16] = 16'(16'h55AA + i * 16'h0F0F);
            pe[16*i +: 16] = 16'(16'hC0DE ^ (i << 4));
        end
        p1[15:0]    = 16'hA5C3;
        p1[255:240] = 16'h8001;

        repeat (3) tick();
        RESET_N = 1'b1;
        @(negedge CLK);
        chk1("rst_wr_ready", wr_ready, 1'b1);
        chk1("rst_empty", empty, 1'b1);
        chk1("rst_dout", dout, 1'b0);
        chk1("rst_err_overflow", err_overflow, 1'b0);
        tick();

        // Counting packet, held without a read, then read out
        write_pkt(p0, 1'b1);
        @(negedge CLK);
        chk1("empty_after_commit", empty, 1'b0);
`ifdef BCRYPT_OUTPUT_DOUBLE_BUF_EN
        chk1("wr_ready_after_commit", wr_ready, 1'b1);
`else
        chk1("wr_ready_after_commit", wr_ready, 1'b0);
`endif
        quiet("dout_quiet_without_rd", 10);
        tick();
        rd_pulse(p0, 1'b1, n);
        @(negedge CLK);
        chk1("empty_after_accept", empty, 1'b1);
        wait_done("pkt0_done");
        tick();
        chk1("wr_ready_after_tx", wr_ready, 1'b1);

        // A5C3 / 8001 boundary pattern
        write_pkt(p1, 1'b1);
        rd_pulse(p1, 1'b1, n);
        wait_done("pkt1_done");
        tick();

        // Ignored reads: while empty, and mid-DATA
        chk1("empty_idle", empty, 1'b1);
        rd_pulse(p2, 1'b0, n);
        @(negedge CLK);
        chk1("no_header_when_empty", dout, 1'b0);
        tick();
        write_pkt(p2, 1'b1);
        rd_pulse(p2, 1'b1, n);
        repeat (50) tick();
        rd_pulse(p2, 1'b0, n);
        wait_done("pkt2_done");
        quiet("dout_quiet_after_ignored_rd", 20);
        chk1("empty_after_ignored_rd", empty, 1'b1);
        tick();

`ifdef BCRYPT_OUTPUT_DOUBLE_BUF_EN
        // Two back-to-back packets into the ping-pong buffers
        write_words(pc, 1'b1);
        chk1("wr_ready_after_pkt_a", wr_ready, 1'b1);
        write_words(pd, 1'b0);
        wr_en = 1'b0;
        chk1("wr_ready_after_pkt_b", wr_ready, 1'b0);
        chk1("empty_two_full", empty, 1'b0);
        rd_pulse(pc, 1'b1, n);
        @(negedge CLK);
        chk1("empty_after_rd_a", empty, 1'b0);
        chk1("wr_ready_during_a", wr_ready, 1'b0);
        wait_done("pkt_a_done");
        tick();
        chk1("wr_ready_after_a", wr_ready, 1'b1);
        rd_pulse(pd, 1'b1, n);
        @(negedge CLK);
        chk1("empty_after_rd_b", empty, 1'b1);
        wait_done("pkt_b_done");
        tick();
`else
        // Overflow write with a committed single buffer
        write_pkt(pc, 1'b1);
        chk1("wr_ready_full", wr_ready, 1'b0);
        din   = 16'hDEAD;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        din   = '0;
        @(negedge CLK);
        chk1("err_overflow_set", err_overflow, 1'b1);
        tick();
        rd_pulse(pc, 1'b1, n);
        wait_done("pkt_overflow_done");
        tick();
        chk1("err_overflow_sticky", err_overflow, 1'b1);
`endif

        // Reset during bit 100 of DATA, then a fresh packet
        write_pkt(pd, 1'b1);
        rd_pulse(pd, 1'b1, n);
        repeat (101) @(posedge CLK);
        #1;
        chk1("bit100_before_reset", dout, pd[100]);
        mon_abort = 1'b1;
        RESET_N   = 1'b0;
        tick();
        @(negedge CLK);
        chk1("reset_mid_dout", dout, 1'b0);
        chk1("reset_mid_empty", empty, 1'b1);
        chk1("reset_mid_wr_ready", wr_ready, 1'b1);
        chk1("reset_mid_err_overflow", err_overflow, 1'b0);
        RESET_N = 1'b1;
        tick();
        mon_abort = 1'b0;
        write_pkt(pe, 1'b1);
        rd_pulse(pe, 1'b1, n);
        wait_done("pkt_after_reset_done");
        quiet("dout_quiet_end", 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcrypt_core_output_serializer.md
# bcrypt_core_output_serializer

Core-side transmitter for the 1-bit result bus that the bcrypt arbiter polls. It buffers one 16×16-bit result packet from a bcrypt core and reports not-empty to the arbiter. On a 1-cycle read strobe it shifts out a header bit followed by 256 data bits, one bit per cycle. It sits at each core's output, between the Blowfish result logic and the top-level `core_empty`/`core_rd_en`/`core_dout` wiring.

## Interface

- `PKT_NUM_WORDS`, 16: 16-bit words per result packet; fixed, other values unsupported.
- `CLK`: in, 1, sole clock.
- `RESET_N`: in, 1, synchronous, active-low reset.
- `din`: in, 16, result word from the core.
- `wr_en`: in, 1, writes `din` as the next word of the packet being filled.
- `wr_ready`: out, 1, a buffer is free for writing.
- `rd_en`: in, 1, 1-cycle read strobe from the arbiter.
- `empty`: out, 1, no committed and unsent packet.
- `dout`: out, 1, serial output.
- `err_overflow`: out, 1, sticky; set by `wr_en` while `wr_ready`=0.

## Operation

- Reset values: `wr_ready`=1, `empty`=1, `dout`=0, `err_overflow`=0; write counter 0; all buffers free; transmitter idle.
- Reset mid-operation drops any partial write and any transmission in progress. `dout`=0 on the cycle after reset is sampled low.
- **Write side:**
  - A 4-bit word counter addresses a 16×16 distributed RAM.
  - Each `wr_en` stores `din` at the counter and increments it.
  - The 16th word (counter 15) commits the buffer and wraps the counter to 0.
  - Word order is fixed: word 1 = pkt_id, words 4–5 = comparator data. This block does not interpret contents.
- **Buffer states:** FREE → FILLING → FULL → SENDING → FREE.
- **Transmitter FSM:**
  - IDLE: `dout`=0. On `rd_en` with `empty`=0 → HEADER, latching the oldest FULL buffer as SENDING.
  - HEADER: `dout`=1 for exactly 1 cycle → DATA.
  - DATA: 256 cycles. Word 0 is sent first, bit 0 (LSB) first within each word. The bit counter is 8 bits and the word index is its upper 4 bits. After bit 255 → IDLE, freeing the buffer.
- `rd_en` while `empty`=1, or while in HEADER/DATA, is ignored with no state change.
- `empty` counts only FULL buffers. The SENDING buffer never counts.
- Simultaneous commit (16th `wr_en`) and `rd_en` on the same edge: `rd_en` sees the pre-edge `empty`. If `empty` was 1 the read is ignored and the new packet becomes visible next cycle.
- A write into the SENDING buffer is impossible. `wr_ready`=0 whenever no buffer is FREE or FILLING.

## Timing

- `rd_en` sampled at edge N: `dout`=1 (header) during cycle N+1, data bit k during cycle N+2+k, and `dout`=0 again from cycle N+258.
- The arbiter's 2-stage input register adds its own latency. `dout` must be 0 in every cycle not listed above so that a stale header is never seen.
- `empty` deasserts 1 cycle after the commit edge. It reasserts 1 cycle after `rd_en` is accepted if no other FULL buffer exists.
- `wr_ready` updates 1 cycle after the commit edge and 1 cycle after the final data bit.
- Write throughput: 1 word/cycle with no bubbles.

## Configuration

- `BCRYPT_OUTPUT_DOUBLE_BUF_EN`:
  - **Defined:** two 16×16 buffers in ping-pong. The core may fill one buffer while the other is SENDING or FULL. `wr_ready` stays 1 until both buffers are non-FREE. Buffers are transmitted in commit order.
  - **Undefined:** single buffer. `wr_ready`=0 from commit until the final data bit is shifted out.

## Test plan

- Reset, then write words 0x0000..0x000F, then no `rd_en`: `empty` falls 1 cycle after the 16th write and `dout` stays 0. Pulse `rd_en`: header 1, then 256 bits whose LSB-first deserialization yields 0x0000..0x000F.
- Pattern word0=0xA5C3, word15=0x8001: bits 2..17 after `rd_en` are 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, and the last bit is 1. `dout`=0 at N+258.
- `rd_en` pulsed while `empty`=1, and again mid-DATA: no header, bit stream unaffected, bit count stays 256.
- Double-buffer enabled, two packets written back-to-back (32 consecutive `wr_en`): `wr_ready` drops after word 32. Two reads return packet A then packet B. `empty`=1 after the second `rd_en`.
- Single-buffer build, 17th `wr_en` before readout: `err_overflow`=1 and stays 1, and packet contents are unchanged.
- `RESET_N`=0 at bit 100 of DATA: `dout`=0 next cycle, `empty`=1, `wr_ready`=1, and a new packet then transmits correctly.
